operand_fetch: RTL and testbench

- Decode/operand-fetch pipeline stage sitting directly upstream of the register file.
- Drives the register file read addresses and consumes its asynchronous read data.
- Resolves RAW hazards by bypassing from the EX, MEM and WB stages, and detects load-use hazards that require a stall.
- Registers the resolved operands, sign-extended immediate and destination into the ID/EX pipeline register.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/forward_mux.sv | 30 +++
 rtl/operand_fetch.sv | 99 +++++++++
 tb/tb_operand_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, instruction field positions and operand-use decode
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SWL   = 6'h2A;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // R-type, branches and stores read rt; everything else only reads rs
    function automatic logic rt_used(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SWL, OP_SW};
    endfunction

endpackage

// File: rtl/forward_mux.sv
// forward_mux: resolve one source operand from regfile data and the EX/MEM/WB bypass paths
module forward_mux #(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] reg_data,
    input  logic                 ex_wr_en,
    input  logic                 ex_load,
    input  logic [ADDR_SIZE-1:0] ex_wr_addr,
    input  logic [WORD_SIZE-1:0] ex_wr_data,
    input  logic                 mem_wr_en,
    input  logic [ADDR_SIZE-1:0] mem_wr_addr,
    input  logic [WORD_SIZE-1:0] mem_wr_data,
    input  logic                 wb_wr_en,
    input  logic [ADDR_SIZE-1:0] wb_wr_addr,
    input  logic [WORD_SIZE-1:0] wb_wr_data,
    output logic [WORD_SIZE-1:0] val
);

    // youngest producer wins; a load in EX has no data yet, so it is skipped
    always_comb begin
        val = (addr == '0)                                   ? '0 :
              (ex_wr_en && !ex_load && ex_wr_addr == addr)   ? ex_wr_data :
              (mem_wr_en && mem_wr_addr == addr)             ? mem_wr_data :
              (wb_wr_en && wb_wr_addr == addr)               ? wb_wr_data :
                                                               reg_data;
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: ID stage operand resolution, load-use detection and ID/EX pipeline register
module operand_fetch
    import mips_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [WORD_SIZE-1:0] id_instr,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic                 stall_out,
    output logic [ADDR_SIZE-1:0] rs_addr,
    output logic [ADDR_SIZE-1:0] rt_addr,
    input  logic [WORD_SIZE-1:0] rs_data,
    input  logic [WORD_SIZE-1:0] rt_data,
    input  logic                 ex_wr_en,
    input  logic                 ex_load,
    input  logic [ADDR_SIZE-1:0] ex_wr_addr,
    input  logic [WORD_SIZE-1:0] ex_wr_data,
    input  logic                 mem_wr_en,
    input  logic [ADDR_SIZE-1:0] mem_wr_addr,
    input  logic [WORD_SIZE-1:0] mem_wr_data,
    input  logic                 wb_wr_en,
    input  logic [ADDR_SIZE-1:0] wb_wr_addr,
    input  logic [WORD_SIZE-1:0] wb_wr_data,
    output logic                 ex_valid,
    output logic [WORD_SIZE-1:0] ex_pc,
    output logic [WORD_SIZE-1:0] ex_instr,
    output logic [WORD_SIZE-1:0] ex_rs_val,
    output logic [WORD_SIZE-1:0] ex_rt_val,
    output logic [WORD_SIZE-1:0] ex_imm,
    output logic [ADDR_SIZE-1:0] ex_dst
);

    logic [5:0]           op;
    logic                 rt_use;
    logic                 lu;
    logic [WORD_SIZE-1:0] rs_val;
    logic [WORD_SIZE-1:0] rt_val;
    logic [WORD_SIZE-1:0] imm;
    logic [ADDR_SIZE-1:0] dst;

    assign op      = id_instr[OP_HI:OP_LO];
    assign rs_addr = id_instr[RS_HI:RS_LO];
    assign rt_addr = id_instr[RT_HI:RT_LO];
    assign rt_use  = rt_used(op);
    assign imm     = {{(WORD_SIZE-16){id_instr[IMM_HI]}}, id_instr[IMM_HI:IMM_LO]};
    assign dst     = (op == OP_RTYPE) ? id_instr[RD_HI:RD_LO] : id_instr[RT_HI:RT_LO];

    // a load in EX whose target is read here cannot be bypassed this cycle
    always_comb begin
        lu = id_valid && ex_load && ex_wr_en && (ex_wr_addr != '0) &&
             ((ex_wr_addr == rs_addr) || (rt_use && ex_wr_addr == rt_addr));
    end

    assign stall_out = lu || stall_in;

    forward_mux #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) u_rs_mux (
        .addr(rs_addr), .reg_data(rs_data),
        .ex_wr_en(ex_wr_en), .ex_load(ex_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .val(rs_val)
    );

    forward_mux #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) u_rt_mux (
        .addr(rt_addr), .reg_data(rt_data),
        .ex_wr_en(ex_wr_en), .ex_load(ex_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .val(rt_val)
    );

    // ID/EX register: downstream stall holds everything, flush and load-use insert a zeroed bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_instr  <= '0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_imm    <= '0;
            ex_dst    <= '0;
        end else if (!stall_in) begin
            ex_valid  <= (flush || lu) ? 1'b0 : id_valid;
            ex_pc     <= (flush || lu) ? '0 : id_pc;
            ex_instr  <= (flush || lu) ? '0 : id_instr;
            ex_rs_val <= (flush || lu) ? '0 : rs_val;
            ex_rt_val <= (flush || lu) ? '0 : rt_val;
            ex_imm    <= (flush || lu) ? '0 : imm;
            ex_dst    <= (flush || lu) ? '0 : dst;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed plus randomized checks of operand_fetch against a behavioural model
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, stall_in, flush;
    logic [31:0] id_instr, id_pc;
    logic        stall_out;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        ex_wr_en, ex_load, mem_wr_en, wb_wr_en;
    logic [4:0]  ex_wr_addr, mem_wr_addr, wb_wr_addr;
    logic [31:0] ex_wr_data, mem_wr_data, wb_wr_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_instr, ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dst;

    logic [31:0] rf [32];
    int n_assert = 0;
    int n_fail = 0;

    logic        m_valid, m_dc;
    logic [31:0] m_pc, m_instr, m_rs, m_rt, m_imm;
    logic [4:0]  m_dst;

    always #5 clk = ~clk;

    assign rs_data = rf[id_instr[25:21]];
    assign rt_data = rf[id_instr[20:16]];

    operand_fetch dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .ex_wr_en(ex_wr_en), .ex_load(ex_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_dst(ex_dst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic reads_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h04 || op == 6'h05 || (op >= 6'h28 && op <= 6'h2B);
    endfunction

    // value the instruction should see for register r: newest in-flight result, else the regfile
    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 0) return 0;
        if (ex_wr_en && !ex_load && ex_wr_addr == r) return ex_wr_data;
        if (mem_wr_en && mem_wr_addr == r) return mem_wr_data;
        if (wb_wr_en && wb_wr_addr == r) return wb_wr_data;
        return rf[r];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_dc = 0;
        m_pc = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_dst = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
        if (!m_dc) begin
            chk({tag, ".pc"}, ex_pc, m_pc);
            chk({tag, ".instr"}, ex_instr, m_instr);
            chk({tag, ".rs"}, ex_rs_val, m_rs);
            chk({tag, ".rt"}, ex_rt_val, m_rt);
            chk({tag, ".imm"}, ex_imm, m_imm);
            chk({tag, ".dst"}, 32'(ex_dst), 32'(m_dst));
        end
    endtask

    task automatic clear_fwd();
        ex_wr_en = 0; ex_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
        mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
        wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
    endtask

    // inputs are already driven; check ID-side outputs, clock once, check ID/EX register
    task automatic step(input string tag);
        logic [4:0] rs, rt;
        logic hz;
        #1;
        rs = id_instr[25:21];
        rt = id_instr[20:16];
        hz = id_valid && ex_load && ex_wr_en && ex_wr_addr != 0 &&
             (ex_wr_addr == rs || (reads_rt(id_instr[31:26]) && ex_wr_addr == rt));
        chk({tag, ".rs_addr"}, 32'(rs_addr), 32'(rs));
        chk({tag, ".rt_addr"}, 32'(rt_addr), 32'(rt));
        chk({tag, ".stall_out"}, 32'(stall_out), 32'(hz || stall_in));
        if (!stall_in) begin
            if (flush || hz) begin
                m_valid = 0; m_dc = 1;
            end else begin
                m_valid = id_valid; m_dc = 0;
                m_pc = id_pc; m_instr = id_instr;
                m_rs = operand(rs); m_rt = operand(rt);
                m_imm = {{16{id_instr[15]}}, id_instr[15:0]};
                m_dst = id_instr[31:26] == 0 ? id_instr[15:11] : rt;
            end
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        rst = 1; id_valid = 0; id_instr = 0; id_pc = 0; stall_in = 0; flush = 0;
        clear_fwd();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        @(negedge clk);
        rst = 0;

        rf[9] = 5; rf[10] = 7;
        id_valid = 1; id_instr = 32'h012A4020; id_pc = 32'h100;
        step("add");
        chk("add.dst_const", 32'(ex_dst), 32'd8);
        chk("add.rs_const", ex_rs_val, 32'd5);

        ex_wr_en = 1; ex_wr_addr = 9; ex_wr_data = 32'h11;
        mem_wr_en = 1; mem_wr_addr = 9; mem_wr_data = 32'h22;
        wb_wr_en = 1; wb_wr_addr = 10; wb_wr_data = 32'h33;
        id_pc = 32'h104;
        step("fwd");
        chk("fwd.rs_const", ex_rs_val, 32'h11);
        chk("fwd.rt_const", ex_rt_val, 32'h33);

        clear_fwd();
        ex_wr_en = 1; ex_load = 1; ex_wr_addr = 9; id_pc = 32'h108;
        step("lu");
        chk("lu.valid_const", 32'(ex_valid), 32'd0);
        clear_fwd();
        mem_wr_en = 1; mem_wr_addr = 9; mem_wr_data = 32'h44;
        step("lu_mem");
        chk("lu_mem.rs_const", ex_rs_val, 32'h44);

        clear_fwd();
        ex_wr_en = 1; ex_load = 1; ex_wr_addr = 9;
        id_instr = 32'h2009FFFF; id_pc = 32'h10C;
        step("addi");
        chk("addi.imm_const", ex_imm, 32'hFFFFFFFF);
        clear_fwd();
        ex_wr_en = 1; ex_wr_addr = 0; ex_wr_data = 32'hDEAD;
        mem_wr_en = 1; mem_wr_addr = 0; mem_wr_data = 32'hBEEF;
        id_instr = 32'h00004020;
        step("zero");
        chk("zero.rs_const", ex_rs_val, 32'h0);

        clear_fwd();
        id_instr = 32'h012A4020; id_pc = 32'h110;
        step("pre_hold");
        stall_in = 1; flush = 1; id_pc = 32'h999;
        step("hold_flush");
        stall_in = 0;
        step("flush");
        flush = 0;
        step("post_flush");

        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        chk("async_rst.valid", 32'(ex_valid), 32'd0);
        chk("async_rst.rs", ex_rs_val, 32'd0);
        chk("async_rst.pc", ex_pc, 32'd0);
        @(negedge clk);
        rst = 0;

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [5:0] op;
            r = $urandom_range(0, 5);
            op = r == 0 ? 6'h00 : r == 1 ? 6'h04 : r == 2 ? 6'h05 :
                 r == 3 ? 6'(6'h28 + $urandom_range(0, 3)) : r == 4 ? 6'h08 : 6'($urandom);
            id_valid = $urandom_range(0, 7) != 0;
            id_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            id_pc = $urandom;
            stall_in = $urandom_range(0, 9) == 0;
            flush = $urandom_range(0, 9) == 0;
            ex_wr_en = $urandom_range(0, 1); ex_load = $urandom_range(0, 2) == 0;
            ex_wr_addr = 5'($urandom_range(0, 7)); ex_wr_data = $urandom;
            mem_wr_en = $urandom_range(0, 1);
            mem_wr_addr = 5'($urandom_range(0, 7)); mem_wr_data = $urandom;
            wb_wr_en = $urandom_range(0, 1);
            wb_wr_addr = 5'($urandom_range(0, 7)); wb_wr_data = $urandom;
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = $urandom;
            step("rand");
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
